// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit is retired per cycle into
// a 2*WIDTH+2 bit accumulator. Operands arrive and the product leaves over valid/ready handshakes.
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 unsigned_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 busy_o
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N);
    localparam int AW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

`ifdef COMM_ASSERT
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $fatal(1, "booth_mul_seq: WIDTH must be even and >= 4");
    end
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   w_acc_nxt;
    logic [AW-1:0]   r_mcand;
    logic [AW-1:0]   w_mcand_nxt;
    logic [BW-1:0]   r_bext;
    logic [BW-1:0]   w_bext_nxt;
    logic [CW-1:0]   r_idx;
    logic [CW-1:0]   w_idx_nxt;
    logic            r_out_valid;
    logic            w_out_valid_nxt;
    logic [AW-1:0]   w_pp;
    logic            w_accept;
    logic            w_ext_a;
    logic            w_ext_b;

    assign in_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign busy_o      = (r_state != S_IDLE);
    assign out_valid_o = r_out_valid;
    assign result_o    = r_acc[2*WIDTH-1:0];

    assign w_ext_a  = !unsigned_i && a_i[WIDTH-1];
    assign w_ext_b  = !unsigned_i && b_i[WIDTH-1];
    assign w_accept = in_valid_i && (r_state == S_IDLE) && !flush_i;

    // Multiplicand is pre-shifted by 2 per digit and the Booth window always sits
    // at bits [2:0] of the shifting multiplier, so no variable shifter is needed.
    always_comb begin
        w_pp = '0;
        case (r_bext[2:0])
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = r_mcand << 1;
            3'b100:         w_pp = -(r_mcand << 1);
            3'b101, 3'b110: w_pp = -r_mcand;
            default:        w_pp = '0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_mcand_nxt     = r_mcand;
        w_bext_nxt      = r_bext;
        w_idx_nxt       = r_idx;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_mcand_nxt = {{(AW - WIDTH){w_ext_a}}, a_i};
                    w_bext_nxt  = {w_ext_b, w_ext_b, b_i, 1'b0};
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_acc_nxt   = r_acc + w_pp;
                w_mcand_nxt = r_mcand << 2;
                w_bext_nxt  = r_bext >> 2;
                if (r_idx == LAST_DIGIT) begin
                    w_state_nxt     = S_DONE;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase

        // Flush overrides everything, including a same-cycle accept or delivery.
        if (flush_i) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
            w_acc_nxt       = '0;
            w_idx_nxt       = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_bext      <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_mcand     <= w_mcand_nxt;
            r_bext      <= w_bext_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomized checks of booth_mul_seq (WIDTH=8) against hand-computed
// products and a plain integer multiply.
module tb_booth_mul_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        unsigned_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] result_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    booth_mul_seq #(.WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .unsigned_i  (unsigned_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full operation: accept, count latency, optional back-pressure, deliver.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic u,
                          input logic [15:0] exp, input int hold, input bit pulse,
                          input string tag);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready_o), 32'd1);
        a_i = a; b_i = b; unsigned_i = u; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        a_i = 8'h5A; b_i = 8'hC3; unsigned_i = ~u;
        check({tag, " busy"}, 32'(busy_o), 32'd1);
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " result"}, 32'(result_o), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid_i = i[0];
                a_i = 8'($urandom);
                b_i = 8'($urandom);
            end
            tick();
            check({tag, " hold valid"}, 32'(out_valid_o), 32'd1);
            check({tag, " hold result"}, 32'(result_o), 32'(exp));
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, " post valid"}, 32'(out_valid_o), 32'd0);
        check({tag, " post ready"}, 32'(in_ready_o), 32'd1);
        check({tag, " post hold"}, 32'(result_o), 32'(exp));
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic u);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = u ? {8'h00, a} : {{8{a[7]}}, a};
        eb = u ? {8'h00, b} : {{8{b[7]}}, b};
        return ea * eb;
    endfunction

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        ru;
        int          lat;

        // Reset behaviour
        rst_i = 1'b1;
        tick();
        tick();
        check("rst in_ready gated", 32'(in_ready_o), 32'd0);
        check("rst out_valid", 32'(out_valid_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst result", 32'(result_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("rst release in_ready", 32'(in_ready_o), 32'd1);

        // Directed products
        run_op(8'h80, 8'h80, 1'b0, 16'h4000, 0, 1'b0, "s80x80");
        run_op(8'hFF, 8'hFF, 1'b1, 16'hFE01, 0, 1'b0, "uFFxFF");
        run_op(8'hFF, 8'h7F, 1'b0, 16'hFF81, 0, 1'b0, "sFFx7F");
        run_op(8'hFF, 8'h7F, 1'b1, 16'h7E81, 0, 1'b0, "uFFx7F");
        run_op(8'h7F, 8'h80, 1'b0, 16'hC080, 2, 1'b0, "s7Fx80");

        // Back-pressure for 10 cycles with ignored in_valid pulses
        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 10, 1'b1, "backpressure");
        tick();
        check("bp no stray accept", 32'(busy_o), 32'd0);

        // Flush in the second CALC cycle
        a_i = 8'h07; b_i = 8'h09; unsigned_i = 1'b0; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush busy", 32'(busy_o), 32'd0);
        check("flush out_valid", 32'(out_valid_o), 32'd0);
        check("flush in_ready", 32'(in_ready_o), 32'd1);
        check("flush acc cleared", 32'(result_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush no late valid", 32'(out_valid_o), 32'd0);
        end
        run_op(8'h03, 8'h05, 1'b0, 16'h000F, 0, 1'b0, "s3x5");

        // Flush coincident with the input handshake cancels the capture
        a_i = 8'h11; b_i = 8'h22; in_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        in_valid_i = 1'b0; flush_i = 1'b0;
        check("flush vs accept busy", 32'(busy_o), 32'd0);

        // Flush together with out_ready in DONE discards the result
        a_i = 8'h02; b_i = 8'h03; unsigned_i = 1'b1; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("flushdone latency", 32'(lat), 32'd5);
        check("flushdone result", 32'(result_o), 32'h0006);
        flush_i = 1'b1; out_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; out_ready_i = 1'b0;
        check("flushdone out_valid", 32'(out_valid_o), 32'd0);
        check("flushdone result cleared", 32'(result_o), 32'd0);

        // One-cycle reset in the middle of CALC
        a_i = 8'h55; b_i = 8'h66; unsigned_i = 1'b0; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        check("midrst in_ready gated", 32'(in_ready_o), 32'd0);
        check("midrst busy", 32'(busy_o), 32'd0);
        check("midrst out_valid", 32'(out_valid_o), 32'd0);
        check("midrst result", 32'(result_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("midrst release in_ready", 32'(in_ready_o), 32'd1);
        tick();
        check("midrst stays idle", 32'(busy_o), 32'd0);

        // Randomized operations against an integer reference multiply
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ru = 1'($urandom_range(0, 1));
            run_op(ra, rb, ru, ref_mul(ra, rb, ru), int'($urandom_range(0, 3)), 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Iterative radix-4 Booth multiplier sequencer. It accepts one WIDTH×WIDTH signed or unsigned multiply through a valid/ready handshake. It retires one Booth digit per cycle into an accumulator and returns the 2·WIDTH-bit product through a second valid/ready handshake. It is the low-area multiply path for the ALU, built on the same radix-4 digit encoding used by the team's Booth encoder.

## Interface
- WIDTH, 8: operand width; must be even and ≥4 (checked under COMM_ASSERT, $fatal otherwise).
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  block can accept operands.
- a_i  input  WIDTH  multiplicand.
- b_i  input  WIDTH  multiplier (Booth-encoded operand).
- unsigned_i  input  1  0 = both operands signed, 1 = both unsigned; sampled with operands.
- flush_i  input  1  abort the current operation.
- out_valid_o  output  1  result_o holds a finished product.
- out_ready_i  input  1  consumer takes result.
- result_o  output  2*WIDTH  product, two's complement when signed.
- busy_o  output  1  state is not IDLE.

## Operation
- N = WIDTH/2+1 digits per operation. A 3-bit counter suffices for WIDTH=8; size it as clog2(N).
- FSM states and transitions:
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o, capture the operands, clear the accumulator and digit index, and go to CALC.
  - CALC: add one partial product per cycle. After digit N-1, go to DONE.
  - DONE: out_valid_o=1. On out_ready_i, go to IDLE.
- Operand capture:
  - A is extended to WIDTH+2 bits, sign-extended if signed and zero-extended if unsigned.
  - B is extended to WIDTH+3 bits as {ext,ext,b_i,1'b0}, with ext = b_i[WIDTH-1] if signed and 0 if unsigned.
- Digit i uses window w = Bext[2i+2:2i], which corresponds to b[2i+1], b[2i] and b[2i-1], with b[-1]=0.
- Digit decode: 000→0, 001→+1, 010→+1, 011→+2, 100→−2, 101→−1, 110→−1, 111→0.
- Partial product: digit·A, sign-extended to 2·WIDTH+2 bits and shifted left by 2i, then added to the accumulator modulo 2^(2·WIDTH+2).
- The last digit (i=N-1) is +1 for unsigned operands with b[WIDTH-1]=1. Otherwise it is 0, but the cycle is still spent: latency is fixed and never data-dependent.
- result_o = accumulator[2·WIDTH-1:0]. It is registered, stable throughout DONE, and holds its value in IDLE until the next capture clears it.
- in_valid_i while not IDLE is ignored; no operands are captured.
- flush_i (outside reset) in any state: next state is IDLE, out_valid_o drops, and the accumulator and index are cleared. A result in DONE is discarded. A flush in the same cycle as an IDLE handshake cancels the capture, so flush wins.
- Simultaneous out_ready_i and flush_i in DONE: go to IDLE; the result is counted as not delivered.

## Timing
- Reset (rst_i high at an edge): state IDLE, out_valid_o=0, busy_o=0, result_o=0, accumulator, index and operand registers all 0.
- in_ready_o is gated low while rst_i=1 and is 1 in the first cycle after reset is released.
- Reset mid-operation behaves like flush; any in-flight operation is lost.
- Latency: the input handshake at edge E0 puts the block in CALC. Digits are added at edges E1..EN, and out_valid_o=1 from edge EN.
- Because in_ready_o is asserted only in IDLE, the earliest next accept is the edge after the output handshake. Minimum initiation interval is N+2 cycles.
- out_valid_o and result_o must not change while out_valid_o=1 and out_ready_i=0; back-pressure is unbounded.
- All outputs come straight from registers, except in_ready_o (decoded from state and rst_i) and busy_o (decoded from state).

## Test plan
- WIDTH=8, signed, a=0x80, b=0x80 → result_o=0x4000, out_valid_o rising exactly 5 edges after the accept.
- Unsigned, a=0xFF, b=0xFF → 0xFE01. The last digit is +1, so this checks the extra-digit path.
- Signed, a=0xFF (−1), b=0x7F → 0xFF81. Then unsigned with the same operands → 0x7E81.
- Back-pressure: hold out_ready_i=0 for 10 cycles → out_valid_o and result_o stay constant and in_valid_i pulses are not accepted. Then release → in_ready_o=1 the next cycle.
- flush_i at the 2nd CALC cycle → IDLE the next cycle with no out_valid_o. A following op 3×5 (signed) → 0x000F.
- rst_i for one cycle mid-CALC → all outputs at reset values and in_ready_o=1 the cycle after release. Follow with randomized signed and unsigned ops checked against a reference model, with random out_ready_i.
